periodic_frame_tx: RTL and testbench



---
 rtl/periodic_frame_tx_if.sv | 11 +
 rtl/periodic_frame_tx.sv | 158 +++++++++++++++
 tb/tb_periodic_frame_tx.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/periodic_frame_tx_if.sv
// UART transmit-side byte handshake shared by the frame sequencer and the transmitter.
interface periodic_frame_tx_if;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       tx_busy;

    // master pulses tx_start for exactly one cycle with tx_byte valid; the slave raises tx_busy
    // while it shifts that byte and drops it when done. A byte is complete on busy falling.
    modport master (output tx_start, output tx_byte, input tx_busy);
    modport slave  (input tx_start, input tx_byte, output tx_busy);
endinterface

// File: rtl/periodic_frame_tx.sv
// Periodic/triggered frame sequencer: snapshots a payload word and streams
// [header] payload [xor checksum] to a byte UART over a start/busy handshake.
module periodic_frame_tx #(
    parameter int unsigned PERIOD_CYCLES = 1_000_000,
    parameter int          DATA_BYTES    = 4,
    parameter bit          HDR_EN        = 1'b1,
    parameter logic [7:0]  HDR_BYTE      = 8'hA5,
    parameter bit          CSUM_EN       = 1'b1,
    parameter bit          MSB_FIRST     = 1'b1,
    parameter int          RISE_TIMEOUT  = 4
) (
    input  logic                    CLK100MHZ,
    input  logic                    CPU_RESETN,
    input  logic                    en,
    input  logic                    trig,
    input  logic [DATA_BYTES*8-1:0] data_in,
    periodic_frame_tx_if.master     uart,
    output logic                    tick,
    output logic                    frame_active,
    output logic                    frame_done,
    output logic [15:0]             overrun_cnt,
    output logic [2:0]              state_dbg
);
    localparam int              FRAME_LEN = int'(HDR_EN) + DATA_BYTES + int'(CSUM_EN);
    localparam logic [31:0]     PERIOD_TC = 32'(PERIOD_CYCLES - 1);
    localparam logic [4:0]      LAST_IDX  = 5'(FRAME_LEN - 1);
    localparam int              TW        = $clog2(RISE_TIMEOUT + 1);
    localparam logic [TW-1:0]   TO_LAST   = TW'(RISE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT_RISE, S_WAIT_FALL, S_NEXT
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [DATA_BYTES*8-1:0] snap_q, snap_d;
    logic [7:0]              csum_q, csum_d;
    logic [7:0]              tx_byte_q, tx_byte_d;
    logic [4:0]              idx_q, idx_d;
    logic [TW-1:0]           to_q, to_d;
    logic [15:0]             ovr_q, ovr_d;
    logic                    tx_start_q, tx_start_d;
    logic                    active_q, active_d;
    logic                    done_q, done_d;
    logic                    req;
    logic [7:0]              sel_byte;
    int                      pay_idx;

    assign tick = en && (cnt_q == PERIOD_TC);
    assign req  = tick | trig;

    // Byte at the current frame position; payload index is clamped so the shift stays in range
    // while the header or checksum slot is selected.
    always_comb begin
        pay_idx = int'(idx_q) - int'(HDR_EN);
        if (pay_idx < 0) pay_idx = 0;
        if (pay_idx > DATA_BYTES - 1) pay_idx = DATA_BYTES - 1;
        if (MSB_FIRST) pay_idx = DATA_BYTES - 1 - pay_idx;
        if (HDR_EN && idx_q == 5'd0)             sel_byte = HDR_BYTE;
        else if (CSUM_EN && idx_q == LAST_IDX)   sel_byte = csum_q;
        else                                     sel_byte = 8'(snap_q >> (pay_idx * 8));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        snap_d    = snap_q;
        csum_d    = csum_q;
        tx_byte_d = tx_byte_q;
        idx_d     = idx_q;
        to_d      = to_q;
        ovr_d     = ovr_q;

        if (!en)                   cnt_d = '0;
        else if (cnt_q == PERIOD_TC) cnt_d = '0;
        else                       cnt_d = cnt_q + 32'd1;

        if (req && state_q != S_IDLE && ovr_q != 16'hFFFF) ovr_d = ovr_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    snap_d  = data_in;
                    csum_d  = '0;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                tx_byte_d = sel_byte;
                state_d   = S_START;
            end
            S_START: begin
                csum_d  = csum_q ^ tx_byte_q;
                to_d    = '0;
                state_d = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                // A transmitter that never acknowledges must not stall the frame forever.
                if (uart.tx_busy)        state_d = S_WAIT_FALL;
                else if (to_q == TO_LAST) state_d = S_NEXT;
                else                     to_d = to_q + TW'(1);
            end
            S_WAIT_FALL: begin
                if (!uart.tx_busy) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered decodes of the next state, so they line up with state_q.
        tx_start_d = (state_d == S_START);
        active_d   = (state_d != S_IDLE);
        done_d     = (state_d == S_NEXT) && (idx_d == LAST_IDX);
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            snap_q     <= '0;
            csum_q     <= '0;
            tx_byte_q  <= '0;
            idx_q      <= '0;
            to_q       <= '0;
            ovr_q      <= '0;
            tx_start_q <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            csum_q     <= csum_d;
            tx_byte_q  <= tx_byte_d;
            idx_q      <= idx_d;
            to_q       <= to_d;
            ovr_q      <= ovr_d;
            tx_start_q <= tx_start_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    assign uart.tx_start = tx_start_q;
    assign uart.tx_byte  = tx_byte_q;
    assign frame_active  = active_q;
    assign frame_done    = done_q;
    assign overrun_cnt   = ovr_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_periodic_frame_tx.sv
// Bench for periodic_frame_tx: two configurations, behavioural UART models, queue scoreboard.
module tb_periodic_frame_tx;
    logic        clk;
    logic        rstn;
    logic        en_a, trig_a, en_b, trig_b;
    logic [31:0] data_a;
    logic [15:0] data_b;
    logic        tick_a, active_a, done_pulse_a, tick_b, active_b, done_pulse_b;
    logic [15:0] ovr_a, ovr_b;
    logic [2:0]  dbg_a, dbg_b;

    periodic_frame_tx_if if_a ();
    periodic_frame_tx_if if_b ();

    periodic_frame_tx #(.PERIOD_CYCLES(100)) dut_a (
        .CLK100MHZ(clk), .CPU_RESETN(rstn), .en(en_a), .trig(trig_a), .data_in(data_a),
        .uart(if_a), .tick(tick_a), .frame_active(active_a), .frame_done(done_pulse_a),
        .overrun_cnt(ovr_a), .state_dbg(dbg_a));

    periodic_frame_tx #(.PERIOD_CYCLES(100), .DATA_BYTES(2), .HDR_EN(1'b0), .CSUM_EN(1'b0),
                        .MSB_FIRST(1'b0)) dut_b (
        .CLK100MHZ(clk), .CPU_RESETN(rstn), .en(en_b), .trig(trig_b), .data_in(data_b),
        .uart(if_b), .tick(tick_b), .frame_active(active_b), .frame_done(done_pulse_b),
        .overrun_cnt(ovr_b), .state_dbg(dbg_b));

    // clock / reset-relative cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) begin
        if (!rstn) cyc = 0;
        else       cyc = cyc + 1;
    end

    // UART models: busy rises on the negedge after tx_start and stays up busy_len cycles
    int busy_len_a = 10;
    int busy_left_a = 0;
    bit never_a = 1'b0;
    int busy_left_b = 0;

    always @(negedge clk) begin
        if (!rstn) begin
            busy_left_a = 0;
            if_a.tx_busy = 1'b0;
        end else if (busy_left_a > 0) begin
            busy_left_a--;
            if (busy_left_a == 0) if_a.tx_busy = 1'b0;
        end else if (if_a.tx_start && !never_a) begin
            if_a.tx_busy = 1'b1;
            busy_left_a = busy_len_a;
        end
        if (!rstn) begin
            busy_left_b = 0;
            if_b.tx_busy = 1'b0;
        end else if (busy_left_b > 0) begin
            busy_left_b--;
            if (busy_left_b == 0) if_b.tx_busy = 1'b0;
        end else if (if_b.tx_start) begin
            if_b.tx_busy = 1'b1;
            busy_left_b = 5;
        end
    end

    // monitors
    logic [7:0] got_a[$], got_b[$];
    int         ts_a[$], ts_b[$];
    int         done_a = 0, done_b = 0, act_viol_a = 0, act_viol_b = 0, tick_b_cnt = 0;

    always @(negedge clk) begin
        if (if_a.tx_start) begin
            got_a.push_back(if_a.tx_byte);
            ts_a.push_back(cyc);
            if (!active_a) act_viol_a++;
        end
        if (if_b.tx_start) begin
            got_b.push_back(if_b.tx_byte);
            ts_b.push_back(cyc);
            if (!active_b) act_viol_b++;
        end
        if (done_pulse_a) done_a++;
        if (done_pulse_b) done_b++;
        if (tick_b) tick_b_cnt++;
    end

    // scoreboard
    logic [7:0] exp_q[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference frame: [A5] payload bytes in chosen order, [xor of every earlier byte].
    task automatic build_frame(input logic [127:0] data, input int nb, input bit hdr,
                               input bit csum, input bit msb);
        logic [7:0] b, x;
        int k;
        exp_q.delete();
        x = 8'h00;
        if (hdr) begin
            exp_q.push_back(8'hA5);
            x = x ^ 8'hA5;
        end
        for (int i = 0; i < nb; i++) begin
            k = msb ? nb - 1 - i : i;
            b = 8'(data >> (8 * k));
            exp_q.push_back(b);
            x = x ^ b;
        end
        if (csum) exp_q.push_back(x);
    endtask

    task automatic compare_a(input int off, input string tag);
        logic [7:0] g;
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (off + i < got_a.size()) ? got_a[off + i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), {24'd0, g}, {24'd0, exp_q[i]});
        end
    endtask

    task automatic compare_b(input string tag);
        logic [7:0] g;
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got_b.size()) ? got_b[i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), {24'd0, g}, {24'd0, exp_q[i]});
        end
    endtask

    task automatic wait_bytes_a(input int n, input int budget, input string tag);
        int k = 0;
        while (got_a.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_bytes_seen"}, 32'(got_a.size() >= n), 32'd1);
    endtask

    task automatic wait_done_a(input int n, input int budget, input string tag);
        int k = 0;
        while (done_a < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_seen"}, 32'(done_a >= n), 32'd1);
    endtask

    task automatic clear_a();
        got_a.delete();
        ts_a.delete();
        done_a = 0;
    endtask

    task automatic pulse_trig_a();
        repeat (2) @(negedge clk);
        trig_a = 1'b1;
        @(negedge clk);
        trig_a = 1'b0;
    endtask

    int tc, t_acc, k, win, n_ovr;

    initial begin
        rstn = 1'b0; en_a = 1'b0; en_b = 1'b0; trig_a = 1'b0; trig_b = 1'b0;
        data_a = 32'h0000_2456; data_b = 16'hBEEF;
        if_a.tx_busy = 1'b0; if_b.tx_busy = 1'b0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_tx_start", 32'(if_a.tx_start), 32'd0);
        check("rst_tx_byte", 32'(if_a.tx_byte), 32'd0);
        check("rst_tick", 32'(tick_a), 32'd0);
        check("rst_active", 32'(active_a), 32'd0);
        check("rst_done", 32'(done_pulse_a), 32'd0);
        check("rst_overrun", 32'(ovr_a), 32'd0);

        // periodic frame after reset, payload changed right after acceptance
        en_a = 1'b1;
        rstn = 1'b1;
        clear_a();
        k = 0;
        while (!tick_a && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("first_tick_cycle", 32'(cyc), 32'd99);
        @(negedge clk);
        data_a = 32'hFFFF_FFFF;
        wait_bytes_a(6, 200, "t1");
        wait_done_a(1, 100, "t1");
        en_a = 1'b0;
        build_frame(128'h0000_2456, 4, 1'b1, 1'b1, 1'b1);
        compare_a(0, "t1");
        check("t1_first_start_cycle", 32'(ts_a.size() > 0 ? ts_a[0] : -1), 32'd101);
        repeat (30) @(negedge clk);
        check("t1_byte_count", 32'(got_a.size()), 32'd6);
        check("t1_done_pulses", 32'(done_a), 32'd1);
        check("t1_active_during_tx", 32'(act_viol_a), 32'd0);
        check("t1_overrun", 32'(ovr_a), 32'd0);
        check("t1_active_after", 32'(active_a), 32'd0);

        // LSB-first, headerless two-byte frame on trig only
        repeat (2) @(negedge clk);
        trig_b = 1'b1;
        tc = cyc;
        @(negedge clk);
        trig_b = 1'b0;
        k = 0;
        while ((got_b.size() < 2 || done_b < 1) && k < 200) begin
            @(negedge clk);
            k++;
        end
        repeat (20) @(negedge clk);
        build_frame(128'hBEEF, 2, 1'b0, 1'b0, 1'b0);
        compare_b("t2");
        check("t2_byte_count", 32'(got_b.size()), 32'd2);
        check("t2_latency", 32'(ts_b.size() > 0 ? ts_b[0] - tc : -1), 32'd2);
        check("t2_active_during_tx", 32'(act_viol_b), 32'd0);
        check("t2_no_tick", 32'(tick_b_cnt), 32'd0);
        check("t2_done_pulses", 32'(done_b), 32'd1);
        check("t2_overrun", 32'(ovr_b), 32'd0);

        // transmitter never acknowledges: each byte released after the rise timeout
        never_a = 1'b1;
        data_a = $urandom;
        clear_a();
        pulse_trig_a();
        wait_bytes_a(6, 200, "t3");
        wait_done_a(1, 50, "t3");
        build_frame(128'(data_a), 4, 1'b1, 1'b1, 1'b1);
        compare_a(0, "t3");
        // START + 4 timeout cycles + NEXT + LOAD before the following START
        for (int i = 1; i < 6; i++)
            check($sformatf("t3_spacing%0d", i),
                  32'(i < ts_a.size() ? ts_a[i] - ts_a[i-1] : -1), 32'd7);
        never_a = 1'b0;

        // random payloads and busy lengths
        for (int r = 0; r < 3; r++) begin
            busy_len_a = $urandom_range(1, 20);
            data_a = $urandom;
            clear_a();
            pulse_trig_a();
            wait_bytes_a(6, 300, "rnd");
            wait_done_a(1, 100, "rnd");
            build_frame(128'(data_a), 4, 1'b1, 1'b1, 1'b1);
            compare_a(0, $sformatf("rnd%0d", r));
            check($sformatf("rnd%0d_overrun", r), 32'(ovr_a), 32'd0);
        end

        // frame outlasts the period; a trig coinciding with the accepted tick is one request
        busy_len_a = 300;
        data_a = $urandom;
        build_frame(128'(data_a), 4, 1'b1, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        clear_a();
        en_a = 1'b1;
        repeat (99) @(negedge clk);
        check("t4_tick_at_accept", 32'(tick_a), 32'd1);
        t_acc = cyc;
        trig_a = 1'b1;
        @(negedge clk);
        trig_a = 1'b0;
        wait_bytes_a(7, 2500, "t4");
        // frame stays busy for L*(busy+3) cycles; every tick inside that window is dropped
        win = 6 * (300 + 3);
        n_ovr = win / 100;
        compare_a(0, "t4");
        check("t4_first_start", 32'(ts_a.size() > 0 ? ts_a[0] - t_acc : -1), 32'd2);
        check("t4_overrun", 32'(ovr_a), 32'(n_ovr));
        check("t4_next_frame_start", 32'(ts_a.size() > 6 ? ts_a[6] - t_acc : -1),
              32'(100 * (n_ovr + 1) + 2));
        check("t4_next_frame_hdr", 32'(got_a.size() > 6 ? got_a[6] : 8'hxx), 32'hA5);

        // asynchronous reset after the second byte of the next frame
        wait_bytes_a(8, 400, "t5");
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("t5_async_tx_start", 32'(if_a.tx_start), 32'd0);
        check("t5_async_tx_byte", 32'(if_a.tx_byte), 32'd0);
        check("t5_async_active", 32'(active_a), 32'd0);
        check("t5_async_overrun", 32'(ovr_a), 32'd0);
        check("t5_async_tick", 32'(tick_a), 32'd0);
        busy_len_a = 10;
        repeat (3) @(negedge clk);
        clear_a();
        rstn = 1'b1;
        wait_bytes_a(6, 300, "t5");
        wait_done_a(1, 100, "t5");
        compare_a(0, "t5");
        check("t5_first_start_cycle", 32'(ts_a.size() > 0 ? ts_a[0] : -1), 32'd101);
        check("t5_overrun", 32'(ovr_a), 32'd0);
        en_a = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
